// File: rtl/normal_matrix_memory.sv
// Normal matrix row store: 96-bit rows filled by a 32-bit streaming write port
// and read with a registered one-cycle-latency port that has priority over writes.
module normal_matrix_memory #(
  parameter int ROWS = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        nommatEnable,
  input  logic [5:0]  nommatAddr,
  output logic [95:0] nommatData,
  output logic        nommatValid,
  input  logic        loadStart,
  input  logic [7:0]  loadBase,
  input  logic        loadValid,
  input  logic [31:0] loadData,
  output logic        loadReady
);

  localparam logic [6:0] ROW_COUNT = 7'(ROWS);
  localparam logic [5:0] LAST_ROW  = 6'(ROWS - 1);

  // Full 64-entry index space keeps the address width exact; rows >= ROWS are never written.
  logic [95:0] rowMem [64];

  logic [5:0] ptrRow, effRow, nextRow;
  logic [1:0] ptrLane, effLane, nextLane;
  logic       accept, writeEn;

  assign loadReady = resetn & ~nommatEnable;
  assign accept    = loadValid & loadReady;
  assign writeEn   = accept & ({1'b0, effRow} < ROW_COUNT);

  always_comb begin
    effRow   = ptrRow;
    effLane  = ptrLane;
    nextRow  = ptrRow;
    nextLane = ptrLane;
    if (loadStart) begin
      effRow  = loadBase[7:2];
      effLane = (loadBase[1:0] == 2'd3) ? 2'd0 : loadBase[1:0];
    end
    if (accept) begin
      if (effLane != 2'd2) begin
        nextRow  = effRow;
        nextLane = effLane + 2'd1;
      end else begin
        nextLane = 2'd0;
        // Out-of-range rows fall back to row 0 just like the last valid row.
        nextRow  = (effRow >= LAST_ROW) ? 6'd0 : effRow + 6'd1;
      end
    end else if (loadStart) begin
      nextRow  = effRow;
      nextLane = effLane;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptrRow  <= 6'd0;
      ptrLane <= 2'd0;
    end else begin
      ptrRow  <= nextRow;
      ptrLane <= nextLane;
    end
  end

  always_ff @(posedge clk) begin
    if (writeEn) begin
      case (effLane)
        2'd0:    rowMem[effRow][95:64] <= loadData;
        2'd1:    rowMem[effRow][63:32] <= loadData;
        default: rowMem[effRow][31:0]  <= loadData;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      nommatValid <= 1'b0;
      nommatData  <= 96'h0;
    end else begin
      nommatValid <= nommatEnable;
      if (nommatEnable) begin
        if ({1'b0, nommatAddr} < ROW_COUNT) nommatData <= rowMem[nommatAddr];
        else                                 nommatData <= 96'h0;
      end
    end
  end

endmodule

// File: tb/tb_normal_matrix_memory.sv
// Directed bench for normal_matrix_memory: streaming loads, lane coercion, wrap,
// read/write priority, out-of-range rows and mid-stream reset.
module tb_normal_matrix_memory;
  logic        clk = 1'b0;
  logic        resetn;
  logic        nommatEnable;
  logic [5:0]  nommatAddr;
  logic [95:0] nommatData;
  logic        nommatValid;
  logic        loadStart;
  logic [7:0]  loadBase;
  logic        loadValid;
  logic [31:0] loadData;
  logic        loadReady;

  int errors = 0;
  int checks = 0;

  normal_matrix_memory #(.ROWS(32)) dut (
    .clk(clk), .resetn(resetn),
    .nommatEnable(nommatEnable), .nommatAddr(nommatAddr),
    .nommatData(nommatData), .nommatValid(nommatValid),
    .loadStart(loadStart), .loadBase(loadBase),
    .loadValid(loadValid), .loadData(loadData), .loadReady(loadReady)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic writeWord(input logic [31:0] w);
    loadValid = 1'b1;
    loadData  = w;
    step();
    loadValid = 1'b0;
    loadStart = 1'b0;
  endtask

  task automatic startLoad(input logic [7:0] base, input logic [31:0] w);
    loadStart = 1'b1;
    loadBase  = base;
    writeWord(w);
  endtask

  task automatic readRow(input logic [5:0] a, output logic [95:0] d, output logic v);
    nommatEnable = 1'b1;
    nommatAddr   = a;
    step();
    nommatEnable = 1'b0;
    d = nommatData;
    v = nommatValid;
  endtask

  task automatic test_reset();
    resetn = 1'b0; nommatEnable = 1'b0; nommatAddr = 6'd0;
    loadStart = 1'b0; loadBase = 8'h00; loadValid = 1'b0; loadData = 32'h0;
    step(); step();
    checks++;
    if (nommatValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", nommatValid); end
    checks++;
    if (nommatData !== 96'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", nommatData); end
    checks++;
    if (loadReady !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", loadReady); end
    resetn = 1'b1;
    #1;
    checks++;
    if (loadReady !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b expected 1", loadReady); end
  endtask

  task automatic test_basic_load();
    startLoad(8'h00, 32'h3F800000);
    writeWord(32'h00000000);
    writeWord(32'h00000000);
    nommatEnable = 1'b1; nommatAddr = 6'd0;
    #1;
    checks++;
    if (nommatValid !== 1'b0) begin errors++; $display("FAIL basic_valid_early: got %b expected 0", nommatValid); end
    step();
    nommatEnable = 1'b0;
    checks++;
    if (nommatValid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", nommatValid); end
    checks++;
    if (nommatData !== 96'h3F800000_00000000_00000000) begin
      errors++; $display("FAIL basic_data: got %h expected 3f800000_00000000_00000000", nommatData);
    end
    step();
    checks++;
    if (nommatValid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b expected 0", nommatValid); end
    checks++;
    if (nommatData !== 96'h3F800000_00000000_00000000) begin
      errors++; $display("FAIL basic_data_hold: got %h expected 3f800000_00000000_00000000", nommatData);
    end
  endtask

  task automatic test_lane3_coerce();
    logic [95:0] d; logic v;
    startLoad(8'h04, 32'h11110000);
    writeWord(32'h22222222);
    writeWord(32'h33333333);
    startLoad(8'h07, 32'hAAAAAAAA);
    readRow(6'd1, d, v);
    checks++;
    if (d !== 96'hAAAAAAAA_22222222_33333333) begin
      errors++; $display("FAIL lane3_coerce: got %h expected aaaaaaaa_22222222_33333333", d);
    end
  endtask

  task automatic test_wrap();
    logic [95:0] d; logic v;
    startLoad(8'h7C, 32'h0000C0C0);
    writeWord(32'h0000C1C1);
    writeWord(32'h0000C2C2);
    startLoad(8'h7E, 32'h11111111);
    writeWord(32'h22222222);
    readRow(6'd31, d, v);
    checks++;
    if (d !== 96'h0000C0C0_0000C1C1_11111111) begin
      errors++; $display("FAIL wrap_row31: got %h expected 0000c0c0_0000c1c1_11111111", d);
    end
    readRow(6'd0, d, v);
    checks++;
    if (d !== 96'h22222222_00000000_00000000) begin
      errors++; $display("FAIL wrap_row0: got %h expected 22222222_00000000_00000000", d);
    end
  endtask

  task automatic test_stall();
    logic [95:0] d; logic v;
    loadValid = 1'b1; loadData = 32'h55555555;
    nommatEnable = 1'b1; nommatAddr = 6'd0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (loadReady !== 1'b0) begin errors++; $display("FAIL stall_ready_%0d: got %b expected 0", i, loadReady); end
      step();
    end
    nommatEnable = 1'b0;
    checks++;
    if (nommatData !== 96'h22222222_00000000_00000000) begin
      errors++; $display("FAIL stall_read: got %h expected 22222222_00000000_00000000", nommatData);
    end
    #1;
    checks++;
    if (loadReady !== 1'b1) begin errors++; $display("FAIL stall_release: got %b expected 1", loadReady); end
    step();
    loadValid = 1'b0;
    writeWord(32'h66666666);
    readRow(6'd0, d, v);
    checks++;
    if (d !== 96'h22222222_55555555_66666666) begin
      errors++; $display("FAIL stall_commit: got %h expected 22222222_55555555_66666666", d);
    end
  endtask

  task automatic test_out_of_range();
    logic [95:0] d; logic v;
    readRow(6'd40, d, v);
    checks++;
    if (v !== 1'b1) begin errors++; $display("FAIL oor_valid: got %b expected 1", v); end
    checks++;
    if (d !== 96'h0) begin errors++; $display("FAIL oor_data: got %h expected 0", d); end
    startLoad(8'hA0, 32'hDEADBEEF);
    writeWord(32'hDEADBEEF);
    writeWord(32'hDEADBEEF);
    readRow(6'd1, d, v);
    checks++;
    if (d !== 96'hAAAAAAAA_22222222_33333333) begin
      errors++; $display("FAIL oor_row1: got %h expected aaaaaaaa_22222222_33333333", d);
    end
    readRow(6'd31, d, v);
    checks++;
    if (d !== 96'h0000C0C0_0000C1C1_11111111) begin
      errors++; $display("FAIL oor_row31: got %h expected 0000c0c0_0000c1c1_11111111", d);
    end
    readRow(6'd0, d, v);
    checks++;
    if (d !== 96'h22222222_55555555_66666666) begin
      errors++; $display("FAIL oor_row0: got %h expected 22222222_55555555_66666666", d);
    end
    writeWord(32'h77777777);
    readRow(6'd0, d, v);
    checks++;
    if (d !== 96'h77777777_55555555_66666666) begin
      errors++; $display("FAIL oor_wrap: got %h expected 77777777_55555555_66666666", d);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0]  addrs [4];
    logic [95:0] exps  [4];
    addrs = '{6'd0, 6'd1, 6'd31, 6'd40};
    exps  = '{96'h77777777_55555555_66666666, 96'hAAAAAAAA_22222222_33333333,
              96'h0000C0C0_0000C1C1_11111111, 96'h0};
    nommatEnable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      nommatAddr = addrs[i];
      step();
      checks++;
      if (nommatValid !== 1'b1 || nommatData !== exps[i]) begin
        errors++; $display("FAIL b2b_%0d: got v=%b d=%h expected v=1 d=%h", i, nommatValid, nommatData, exps[i]);
      end
    end
    nommatEnable = 1'b0;
    step();
  endtask

  task automatic test_reset_midflight();
    logic [95:0] d; logic v;
    startLoad(8'h08, 32'h99999999);
    nommatEnable = 1'b1;
    nommatAddr = 6'd0; step();
    nommatAddr = 6'd1; step();
    nommatAddr = 6'd31; resetn = 1'b0;
    #1;
    checks++;
    if (loadReady !== 1'b0) begin errors++; $display("FAIL mid_ready: got %b expected 0", loadReady); end
    step();
    resetn = 1'b1;
    checks++;
    if (nommatValid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", nommatValid); end
    checks++;
    if (nommatData !== 96'h0) begin errors++; $display("FAIL mid_data: got %h expected 0", nommatData); end
    nommatAddr = 6'd40; step();
    nommatEnable = 1'b0;
    checks++;
    if (nommatValid !== 1'b1) begin errors++; $display("FAIL mid_resume: got %b expected 1", nommatValid); end
    step();
    writeWord(32'h12345678);
    readRow(6'd0, d, v);
    checks++;
    if (d !== 96'h12345678_55555555_66666666) begin
      errors++; $display("FAIL mid_ptr: got %h expected 12345678_55555555_66666666", d);
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_lane3_coerce();
    test_wrap();
    test_stall();
    test_out_of_range();
    test_back_to_back();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
